ps2_mouse_cursor: RTL and testbench
===================================

// Module: ps2_mouse_cursor
// PURPOSE
//  Receive-only PS/2 mouse front end. Deserialises 11-bit PS/2 frames into bytes,
//  assembles 3-byte stream-mode packets and accumulates them into a clamped screen cursor.
//  Drives cursorX/cursorY/leftButton for the game FSM and sprite logic.
//  Stream-mode enable (0xF4) is sent by a separate TX block; this block never drives the bus.
// PARAMETERS
//  SCREEN_W        640    horizontal pixels; cursorX range 0..SCREEN_W-1
//  SCREEN_H        480    vertical pixels; cursorY range 0..SCREEN_H-1
//  X_INIT          320    cursorX reset value
//  Y_INIT          240    cursorY reset value
//  TIMEOUT_CYCLES  50000  idle Clk cycles (1 ms @ 50 MHz) that abort a partial frame/packet
// PORTS
//  Clk           in   1   system clock; all logic on rising edge
//  Reset         in   1   asynchronous, active-low reset
//  PS2_CLK       in   1   raw PS/2 clock from pin (asynchronous)
//  PS2_DATA      in   1   raw PS/2 data from pin (asynchronous)
//  cursorX       out  10  cursor column, unsigned
//  cursorY       out  10  cursor row, unsigned, 0 = top
//  leftButton    out  1   left button level from last good packet
//  rightButton   out  1   right button level from last good packet
//  packet_valid  out  1   one-cycle pulse when a packet has been applied
// BEHAVIOUR
//  Reset (Reset=0, async): cursorX=X_INIT, cursorY=Y_INIT, buttons=0, packet_valid=0,
//   bit count=0, byte index=0, timeout counter=0; holds while low, resumes on release.
//  Sync: PS2_CLK/PS2_DATA through 2 FFs each. Edge = synced clk prev 1, now 0.
//  Frame RX (states IDLE, SHIFT): one bit sampled per edge, from synced PS2_DATA.
//   - IDLE: start bit must be 0; a 1 is ignored, remain IDLE. 0 -> SHIFT, count=1.
//   - SHIFT: bits 1..8 data LSB first; bit 9 odd parity over data+parity; bit 10 stop must be 1.
//   - After bit 10 -> IDLE. Good frame: byte_valid pulses cycle after the stop edge.
//   - Bad parity or stop=0: byte dropped, packet byte index forced to 0.
//  Timeout: counter clears on every edge, counts while SHIFT or byte index!=0.
//   At TIMEOUT_CYCLES -> IDLE, bit count=0, byte index=0, partial packet dropped.
//  Packet assembly (byte index 0,1,2, advanced on byte_valid):
//   - byte0 needs bit3=1; else dropped, index stays 0 (resync).
//   - byte0: [0]=L [1]=R [4]=Xsign [5]=Ysign [6]=Xovf [7]=Yovf; byte1=dx[7:0]; byte2=dy[7:0].
//   - After byte2: index->0, apply stage fires next cycle.
//  Apply (registered, 1 cycle): dx={Xsign,byte1}, dy={Ysign,byte2}, 9-bit two's complement.
//   - Axis with ovf bit set uses delta 0; buttons still update.
//   - nx = cursorX + dx, ny = cursorY - dy (mouse +Y is up), in 12-bit signed.
//   - Clamp: <0 -> 0; >SCREEN_W-1 -> SCREEN_W-1 (likewise SCREEN_H for Y).
//   - cursorX/Y, buttons and packet_valid=1 update together.
//  Latency: byte2 stop edge seen cycle N -> byte_valid N+1 -> outputs/packet_valid N+2.
//  Outputs change only on apply or reset. Edges with Reset low are ignored.
// TESTING
//  1 After reset send 0x09,0x10,0x00 -> one packet_valid pulse; leftButton=1, X=336, Y=240.
//  2 From reset send 0x38,0xF0,0xF0 -> X=304, Y=256 (dx=-16, dy=-16 moves down).
//  3 Three packets 0x08,0x7F,0x00 -> X=447,574,639 (clamped).
//    Then two 0x08,0x00,0x7F -> Y=113,0 (clamped).
//  4 Bad parity on byte1 of a packet, then a good 0x0A,0x05,0x00 ->
//    no pulse for the bad packet; then rightButton=1, X=325.
//  5 Send 0x00 (bit3=0), then 0x08,0x01,0x01 -> 0x00 dropped; exactly one pulse; X=321, Y=239.
//  6 Stall after 5 bits for >TIMEOUT_CYCLES, then a full packet -> accepted.
//    Assert Reset low mid-frame -> outputs go to X_INIT/Y_INIT at once; next packet applies from there.

Source files
------------

// File: rtl/ps2_mouse_cursor.sv
// Receive-only PS/2 mouse front end: frame deserialiser, 3-byte packet assembler
// and clamped cursor accumulator with left/right button levels.
module ps2_mouse_cursor #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [9:0] cursorX,
  output logic [9:0] cursorY,
  output logic       leftButton,
  output logic       rightButton,
  output logic       packet_valid
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nx;
  logic [3:0]      bit_cnt, bit_cnt_nx;
  logic            ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic            ps2_data_p0, ps2_data_p1;
  logic            ps2_edge;
  logic [7:0]      shreg;
  logic            par_bit;
  logic            vld_p1, vld_p1_nx;
  logic            err_p1, err_p1_nx;
  logic [1:0]      byte_idx;
  logic [7:0]      byte0, byte1;
  logic [TW-1:0]   tcnt;
  logic            busy, timeout, apply_go;
  logic signed [8:0]  dx, dy;
  logic signed [11:0] nx, ny;

  function automatic logic [9:0] clamp(input logic signed [11:0] v, input int maxv);
    if (v < 0)
      return 10'd0;
    else if (v > maxv)
      return 10'(maxv);
    else
      return v[9:0];
  endfunction

  // Stage 0: pin synchronisers and falling-edge detect (idle-high reset avoids a false edge)
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_clk_p2  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= PS2_CLK;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_clk_p2  <= ps2_clk_p1;
      ps2_data_p0 <= PS2_DATA;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  assign ps2_edge = ps2_clk_p2 & ~ps2_clk_p1;
  assign busy     = (state == SHIFT) || (byte_idx != 2'd0);
  assign timeout  = busy && !ps2_edge && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      tcnt <= '0;
    else if (ps2_edge || !busy || timeout)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end

  // Stage 1: frame receiver
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      vld_p1  <= vld_p1_nx;
      err_p1  <= err_p1_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    vld_p1_nx  = 1'b0;
    err_p1_nx  = 1'b0;
    if (timeout) begin
      state_nx   = IDLE;
      bit_cnt_nx = 4'd0;
    end else if (ps2_edge) begin
      case (state)
        IDLE: begin
          if (!ps2_data_p1) begin
            state_nx   = SHIFT;
            bit_cnt_nx = 4'd1;
          end
        end
        SHIFT: begin
          if (bit_cnt == 4'd10) begin
            state_nx   = IDLE;
            bit_cnt_nx = 4'd0;
            if (ps2_data_p1 && (^{shreg, par_bit}))
              vld_p1_nx = 1'b1;
            else
              err_p1_nx = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (ps2_edge && state == SHIFT) begin
      if (bit_cnt <= 4'd8)
        shreg <= {ps2_data_p1, shreg[7:1]};
      else if (bit_cnt == 4'd9)
        par_bit <= ps2_data_p1;
    end
  end

  // Stage 2: packet assembly; byte0 without bit3 set is discarded to resync
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      byte_idx <= 2'd0;
    else if (timeout || err_p1)
      byte_idx <= 2'd0;
    else if (vld_p1) begin
      case (byte_idx)
        2'd0:    byte_idx <= shreg[3] ? 2'd1 : 2'd0;
        2'd1:    byte_idx <= 2'd2;
        default: byte_idx <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (vld_p1 && byte_idx == 2'd0)
      byte0 <= shreg;
    if (vld_p1 && byte_idx == 2'd1)
      byte1 <= shreg;
  end

  assign apply_go = vld_p1 && (byte_idx == 2'd2) && !timeout;

  // Stage 3: apply deltas (third byte taken straight from the shifter); screen Y grows downward
  always_comb begin
    dx = byte0[6] ? 9'sd0 : $signed({byte0[4], byte1});
    dy = byte0[7] ? 9'sd0 : $signed({byte0[5], shreg});
    nx = $signed({2'b00, cursorX}) + $signed({{3{dx[8]}}, dx});
    ny = $signed({2'b00, cursorY}) - $signed({{3{dy[8]}}, dy});
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cursorX      <= 10'(X_INIT);
      cursorY      <= 10'(Y_INIT);
      leftButton   <= 1'b0;
      rightButton  <= 1'b0;
      packet_valid <= 1'b0;
    end else begin
      packet_valid <= apply_go;
      if (apply_go) begin
        cursorX     <= clamp(nx, SCREEN_W - 1);
        cursorY     <= clamp(ny, SCREEN_H - 1);
        leftButton  <= byte0[0];
        rightButton <= byte0[1];
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor: bit-banged PS/2 frames with hand-computed cursor results.
module tb_ps2_mouse_cursor;

  localparam int HALF = 8;
  localparam int TMO  = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] cursor_x, cursor_y;
  logic       left_btn, right_btn, packet_valid;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  ps2_mouse_cursor #(
    .SCREEN_W(640), .SCREEN_H(480), .X_INIT(320), .Y_INIT(240), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(clk), .Reset(rst_n), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
    .cursorX(cursor_x), .cursorY(cursor_y), .leftButton(left_btn),
    .rightButton(right_btn), .packet_valid(packet_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (packet_valid === 1'b1) pulses++;

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cursor_x !== 10'd320) begin bad++; $display("FAIL reset_x got=%0d exp=320", cursor_x); end
    total++; if (cursor_y !== 10'd240) begin bad++; $display("FAIL reset_y got=%0d exp=240", cursor_y); end
    total++; if ({left_btn, right_btn, packet_valid} !== 3'b000)
      begin bad++; $display("FAIL reset_flags got=%b exp=000", {left_btn, right_btn, packet_valid}); end
  endtask

  task automatic test_basic_move();
    int p0;
    do_reset();
    p0 = pulses;
    send_packet(8'h09, 8'h10, 8'h00);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", pulses - p0); end
    total++; if (left_btn !== 1'b1) begin bad++; $display("FAIL basic_left got=%b exp=1", left_btn); end
    total++; if (cursor_x !== 10'd336) begin bad++; $display("FAIL basic_x got=%0d exp=336", cursor_x); end
    total++; if (cursor_y !== 10'd240) begin bad++; $display("FAIL basic_y got=%0d exp=240", cursor_y); end
  endtask

  task automatic test_negative();
    do_reset();
    send_packet(8'h38, 8'hF0, 8'hF0);
    total++; if (cursor_x !== 10'd304) begin bad++; $display("FAIL neg_x got=%0d exp=304", cursor_x); end
    total++; if (cursor_y !== 10'd256) begin bad++; $display("FAIL neg_y got=%0d exp=256", cursor_y); end
  endtask

  task automatic test_clamp();
    logic [9:0] exp_x [3];
    logic [9:0] exp_y [2];
    exp_x = '{10'd447, 10'd574, 10'd639};
    exp_y = '{10'd113, 10'd0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_packet(8'h08, 8'h7F, 8'h00);
      total++; if (cursor_x !== exp_x[i])
        begin bad++; $display("FAIL clamp_x%0d got=%0d exp=%0d", i, cursor_x, exp_x[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      send_packet(8'h08, 8'h00, 8'h7F);
      total++; if (cursor_y !== exp_y[i])
        begin bad++; $display("FAIL clamp_y%0d got=%0d exp=%0d", i, cursor_y, exp_y[i]); end
    end
    total++; if (cursor_x !== 10'd639) begin bad++; $display("FAIL clamp_xhold got=%0d exp=639", cursor_x); end
  endtask

  task automatic test_bad_parity();
    int p0;
    do_reset();
    p0 = pulses;
    send_byte(8'h08, 1'b0);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (pulses - p0 !== 0) begin bad++; $display("FAIL par_nopulse got=%0d exp=0", pulses - p0); end
    send_packet(8'h0A, 8'h05, 8'h00);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL par_pulses got=%0d exp=1", pulses - p0); end
    total++; if (right_btn !== 1'b1) begin bad++; $display("FAIL par_right got=%b exp=1", right_btn); end
    total++; if (left_btn !== 1'b0) begin bad++; $display("FAIL par_left got=%b exp=0", left_btn); end
    total++; if (cursor_x !== 10'd325) begin bad++; $display("FAIL par_x got=%0d exp=325", cursor_x); end
  endtask

  task automatic test_resync();
    int p0;
    do_reset();
    p0 = pulses;
    send_byte(8'h00, 1'b0);
    send_packet(8'h08, 8'h01, 8'h01);
    total++; if (pulses - p0 !== 1) begin bad++; $display("FAIL resync_pulses got=%0d exp=1", pulses - p0); end
    total++; if (cursor_x !== 10'd321) begin bad++; $display("FAIL resync_x got=%0d exp=321", cursor_x); end
    total++; if (cursor_y !== 10'd239) begin bad++; $display("FAIL resync_y got=%0d exp=239", cursor_y); end
  endtask

  task automatic test_timeout_and_reset();
    do_reset();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TMO + 200) @(negedge clk);
    send_packet(8'h08, 8'h02, 8'h00);
    total++; if (cursor_x !== 10'd322) begin bad++; $display("FAIL tmo_x got=%0d exp=322", cursor_x); end
    send_packet(8'h09, 8'h10, 8'h00);
    total++; if (cursor_x !== 10'd338) begin bad++; $display("FAIL tmo_x2 got=%0d exp=338", cursor_x); end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    total++; if (cursor_x !== 10'd320) begin bad++; $display("FAIL arst_x got=%0d exp=320", cursor_x); end
    total++; if (cursor_y !== 10'd240) begin bad++; $display("FAIL arst_y got=%0d exp=240", cursor_y); end
    total++; if (left_btn !== 1'b0) begin bad++; $display("FAIL arst_left got=%b exp=0", left_btn); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_packet(8'h08, 8'h00, 8'h01);
    total++; if (cursor_x !== 10'd320) begin bad++; $display("FAIL post_x got=%0d exp=320", cursor_x); end
    total++; if (cursor_y !== 10'd239) begin bad++; $display("FAIL post_y got=%0d exp=239", cursor_y); end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_negative();
    test_clamp();
    test_bad_parity();
    test_resync();
    test_timeout_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
